writeback_stage: RTL and testbench
==================================

# writeback_stage

MEM/WB pipeline register and write-back logic of the 5-stage MIPS pipeline. It captures the memory-stage result and extracts and extends sub-word load data. It drives the register bank's `write_register`/`write_data`/`Reg_write` port, masking writes to r0, and counts retired instructions. Optionally it provides a same-edge write-to-read bypass for the decode stage, because register-bank reads are registered and return the old value when a read and a write to the same register share a clock edge.

## Interface
- `RETIRE_W`, 32, width of retired-instruction counter
- `clk` in 1: pipeline clock, all state on rising edge
- `rst` in 1: asynchronous, active-high reset
- `stall` in 1: hold WB register and suppress commit
- `flush` in 1: load a bubble into WB register; wins over `stall`
- `mem_valid` in 1: MEM stage holds a real instruction
- `mem_reg_write` in 1: instruction writes a GPR
- `mem_mem_to_reg` in 1: 1 = load data, 0 = ALU result
- `mem_load_size` in 2: 00 byte, 01 half, 10 word; 11 reserved, treated as word
- `mem_load_unsigned` in 1: zero-extend (lbu/lhu)
- `mem_addr_lo` in 2: byte address bits [1:0]
- `mem_alu_result` in 32: ALU result
- `mem_read_data` in 32: data-memory word
- `mem_write_register` in 5: destination register
- `write_register` out 5: to register bank
- `write_data` out 32: to register bank
- `Reg_write` out 1: to register bank
- `align_err` out 1: misaligned load in WB this cycle
- `retired_count` out RETIRE_W: committed-instruction count
- `rd_reg1`, `rd_reg2` in 5 each (WB_BYPASS_EN only): decode read addresses, same as bank read ports
- `fwd_sel1`, `fwd_sel2` out 1 each (WB_BYPASS_EN only): use `fwd_data` instead of busA/busB
- `fwd_data` out 32 (WB_BYPASS_EN only): bypass value, aligned with busA/busB

## Operation
- WB register fields: valid, reg_write, mem_to_reg, load_size, unsigned, addr_lo, alu_result, read_data, dest.
- Each edge:
  - `flush`=1: valid <= 0, other fields don't-care.
  - else if `stall`=1: hold all fields.
  - else: load all fields from `mem_*`.
- Load extraction is big-endian.
  - Byte: addr_lo 0..3 selects bits [31:24], [23:16], [15:8], [7:0].
  - Half: addr_lo 0 selects [31:16]; addr_lo 2 selects [15:0].
  - Byte and half results are sign- or zero-extended to 32 bits.
- Misaligned: half with addr_lo[0]=1, or word with addr_lo≠0. Only flagged when mem_to_reg=1.
- commit = valid & ~stall.
- `Reg_write` = commit & reg_write & (dest≠0) & ~misaligned.
- `write_data` = mem_to_reg ? extracted load : alu_result.
- `write_register` = dest.
- `align_err` = commit & mem_to_reg & misaligned. The write is suppressed, but the instruction is still retired.
- `retired_count` increments by 1 per commit cycle and wraps modulo 2^RETIRE_W.

## Timing
- Latency: `mem_*` sampled at edge N drives `Reg_write`/`write_data` combinationally during cycle N..N+1. The register bank writes at edge N+1.
- Outputs are pure functions of WB register and `stall`; no `mem_*` input reaches an output combinationally.
- Reset: WB valid=0, fields 0, `retired_count`=0. Hence `Reg_write`=0, `write_data`=0, `write_register`=0, `align_err`=0. With bypass: `fwd_sel1`=`fwd_sel2`=0, `fwd_data`=0.
- Reset asserted mid-stall or mid-flush: everything clears immediately; no commit occurs in the reset cycle.
- `stall` and `flush` together: flush wins. A held instruction is discarded without commit.
- Reading r0 never forwards.

## Configuration
- `WRITEBACK_BYPASS_EN` defined: the bypass is compiled in.
  - At each edge, `fwd_seln` <= `Reg_write` & (`write_register`==`rd_regn`).
  - At each edge, `fwd_data` <= `write_data`.
  - Decode muxes busA/busB against these registered values.
- Not defined: bypass ports and logic are absent. Software or the hazard unit must tolerate the one-cycle stale read.

## Structure
- `pipeline_pkg`:
  - LOAD_BYTE/LOAD_HALF/LOAD_WORD encodings
  - REG_ZERO = 5'd0
  - GPR_W = 32
  - REG_ADDR_W = 5
- Sub-module `load_align`: combinational extractor (size, unsigned, addr_lo, read_data → data, misaligned). It is instanced once.

## Test plan
- Reset, then ALU write: mem_reg_write=1, mem_mem_to_reg=0, alu_result=0x0000_1234, dest=5. Next cycle `Reg_write`=1, `write_register`=5, `write_data`=0x1234, `retired_count`=1.
- lb: read_data=0x80FF_7F01, addr_lo=0, signed, dest=3 → `write_data`=0xFFFF_FF80. lbu at addr_lo=1 → 0x0000_00FF. lh at addr_lo=2 → 0x0000_7F01.
- Write to dest=0 with alu_result=0xDEAD_BEEF → `Reg_write`=0, and `retired_count` still increments.
- lw with addr_lo=2 → `align_err`=1 for one cycle, `Reg_write`=0.
- stall held 3 cycles on a valid write → `Reg_write`=0 throughout, then exactly one write and +1 count on release. `flush`+`stall` in the same cycle → no write, no count.
- WRITEBACK_BYPASS_EN: commit r7=0xCAFE_0001 while rd_reg1=7 and rd_reg2=0 at the same edge → next cycle `fwd_sel1`=1, `fwd_sel2`=0, `fwd_data`=0xCAFE_0001.

Source files
------------

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared widths, load-size encodings and WB register layout
package pipeline_pkg;

  localparam int GPR_W      = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] LOAD_BYTE = 2'b00;
  localparam logic [1:0] LOAD_HALF = 2'b01;
  localparam logic [1:0] LOAD_WORD = 2'b10;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [1:0]            load_size;
    logic                  load_unsigned;
    logic [1:0]            addr_lo;
    logic [GPR_W-1:0]      alu_result;
    logic [GPR_W-1:0]      read_data;
    logic [REG_ADDR_W-1:0] dest;
  } wb_reg_t;

endpackage

// File: rtl/writeback_stage_if.sv
// rtl/writeback_stage_if.sv - MEM-to-WB bundle with MEM (master) and WB (slave) views
interface writeback_stage_if;

  logic                                  mem_valid;
  logic                                  mem_reg_write;
  logic                                  mem_mem_to_reg;
  logic [1:0]                            mem_load_size;
  logic                                  mem_load_unsigned;
  logic [1:0]                            mem_addr_lo;
  logic [pipeline_pkg::GPR_W-1:0]        mem_alu_result;
  logic [pipeline_pkg::GPR_W-1:0]        mem_read_data;
  logic [pipeline_pkg::REG_ADDR_W-1:0]   mem_write_register;

  modport master (
    output mem_valid, mem_reg_write, mem_mem_to_reg, mem_load_size,
           mem_load_unsigned, mem_addr_lo, mem_alu_result, mem_read_data,
           mem_write_register
  );

  modport slave (
    input  mem_valid, mem_reg_write, mem_mem_to_reg, mem_load_size,
           mem_load_unsigned, mem_addr_lo, mem_alu_result, mem_read_data,
           mem_write_register
  );

endinterface

// File: rtl/load_align.sv
// rtl/load_align.sv - big-endian sub-word load extractor with misalignment flag
module load_align
  import pipeline_pkg::*;
(
  input  logic [1:0]       load_size,
  input  logic             load_unsigned,
  input  logic [1:0]       addr_lo,
  input  logic [GPR_W-1:0] read_data,
  output logic [GPR_W-1:0] data,
  output logic             misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed byte/half (byte 0 is the MSB) and extend to a full word.
  always_comb begin
    data       = read_data;
    misaligned = 1'b0;
    byte_sel   = read_data[7:0];
    half_sel   = addr_lo[1] ? read_data[15:0] : read_data[31:16];
    case (addr_lo)
      2'd0:    byte_sel = read_data[31:24];
      2'd1:    byte_sel = read_data[23:16];
      2'd2:    byte_sel = read_data[15:8];
      default: byte_sel = read_data[7:0];
    endcase
    case (load_size)
      LOAD_BYTE: data = load_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      LOAD_HALF: begin
        data       = load_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
        misaligned = addr_lo[0];
      end
      // Reserved size 11 behaves as a word load.
      default: begin
        data       = read_data;
        misaligned = (addr_lo != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MEM/WB register, load write-back and retire counter; WRITEBACK_BYPASS_EN adds decode bypass
module writeback_stage
  import pipeline_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
`ifdef WRITEBACK_BYPASS_EN
  input  logic [REG_ADDR_W-1:0] rd_reg1,
  input  logic [REG_ADDR_W-1:0] rd_reg2,
  output logic                  fwd_sel1,
  output logic                  fwd_sel2,
  output logic [GPR_W-1:0]      fwd_data,
`endif
  writeback_stage_if.slave      mem,
  output logic [REG_ADDR_W-1:0] write_register,
  output logic [GPR_W-1:0]      write_data,
  output logic                  Reg_write,
  output logic                  align_err,
  output logic [RETIRE_W-1:0]   retired_count
);

  wb_reg_t             wb_q, wb_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic [GPR_W-1:0]    load_data;
  logic                load_misaligned;
  logic                commit;
  logic                misaligned;

  // Flush inserts a bubble and wins over stall; stall holds every field.
  always_comb begin
    wb_d = wb_q;
    if (flush) begin
      wb_d.valid = 1'b0;
    end else if (!stall) begin
      wb_d.valid         = mem.mem_valid;
      wb_d.reg_write     = mem.mem_reg_write;
      wb_d.mem_to_reg    = mem.mem_mem_to_reg;
      wb_d.load_size     = mem.mem_load_size;
      wb_d.load_unsigned = mem.mem_load_unsigned;
      wb_d.addr_lo       = mem.mem_addr_lo;
      wb_d.alu_result    = mem.mem_alu_result;
      wb_d.read_data     = mem.mem_read_data;
      wb_d.dest          = mem.mem_write_register;
    end
  end

  // WB pipeline register and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q      <= '0;
      retired_q <= '0;
    end else begin
      wb_q      <= wb_d;
      retired_q <= retired_d;
    end
  end

  load_align u_load_align (
    .load_size     (wb_q.load_size),
    .load_unsigned (wb_q.load_unsigned),
    .addr_lo       (wb_q.addr_lo),
    .read_data     (wb_q.read_data),
    .data          (load_data),
    .misaligned    (load_misaligned)
  );

  // Commit decision and register-bank write port; misaligned loads retire without writing.
  always_comb begin
    commit         = wb_q.valid & ~stall;
    misaligned     = wb_q.mem_to_reg & load_misaligned;
    Reg_write      = commit & wb_q.reg_write & (wb_q.dest != REG_ZERO) & ~misaligned;
    write_data     = wb_q.mem_to_reg ? load_data : wb_q.alu_result;
    write_register = wb_q.dest;
    align_err      = commit & misaligned;
    retired_d      = commit ? retired_q + RETIRE_W'(1) : retired_q;
    retired_count  = retired_q;
  end

`ifdef WRITEBACK_BYPASS_EN
  logic             fwd_sel1_q, fwd_sel1_d;
  logic             fwd_sel2_q, fwd_sel2_d;
  logic [GPR_W-1:0] fwd_data_q, fwd_data_d;

  // Capture this edge's bank write so decode can override the stale registered read.
  always_comb begin
    fwd_sel1_d = Reg_write & (write_register == rd_reg1);
    fwd_sel2_d = Reg_write & (write_register == rd_reg2);
    fwd_data_d = write_data;
  end

  // Bypass registers, aligned with the bank's registered read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_sel1_q <= 1'b0;
      fwd_sel2_q <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_sel1_q <= fwd_sel1_d;
      fwd_sel2_q <= fwd_sel2_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  assign fwd_sel1 = fwd_sel1_q;
  assign fwd_sel2 = fwd_sel2_q;
  assign fwd_data = fwd_data_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - directed and randomized checks of writeback_stage against a behavioural model
module tb_writeback_stage;

  logic clk = 1'b0;
  logic rst;
  logic stall;
  logic flush;

  always #5 clk = ~clk;

  writeback_stage_if bus ();

  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic        Reg_write;
  logic        align_err;
  logic [31:0] retired_count;
`ifdef WRITEBACK_BYPASS_EN
  logic [4:0]  rd_reg1, rd_reg2;
  logic        fwd_sel1, fwd_sel2;
  logic [31:0] fwd_data;
`endif

  writeback_stage #(.RETIRE_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
`ifdef WRITEBACK_BYPASS_EN
    .rd_reg1        (rd_reg1),
    .rd_reg2        (rd_reg2),
    .fwd_sel1       (fwd_sel1),
    .fwd_sel2       (fwd_sel2),
    .fwd_data       (fwd_data),
`endif
    .mem            (bus),
    .write_register (write_register),
    .write_data     (write_data),
    .Reg_write      (Reg_write),
    .align_err      (align_err),
    .retired_count  (retired_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: the instruction sitting in WB plus expected counters.
  logic        m_valid, m_rw, m_m2r, m_uns;
  logic [1:0]  m_size, m_alo;
  logic [31:0] m_alu, m_rd;
  logic [4:0]  m_dest;
  logic [31:0] m_count;
  logic        e_commit, e_we, e_align;
  logic [31:0] e_wd;
  logic        e_fs1, e_fs2;
  logic [31:0] e_fd;

  function automatic logic [31:0] ref_load(input int size, input int uns, input int a, input logic [31:0] rd);
    int unsigned v;
    if (size == 0) begin
      v = (rd >> (8 * (3 - a))) & 32'hFF;
      if (uns == 0 && v >= 128) v = v - 256;
    end else if (size == 1) begin
      v = (rd >> (16 * (1 - a / 2))) & 32'hFFFF;
      if (uns == 0 && v >= 32768) v = v - 65536;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic bit ref_misaligned(input int size, input int a);
    if (size == 1) return (a % 2) != 0;
    if (size >= 2) return a != 0;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_m2r = 0; m_uns = 0; m_size = 0; m_alo = 0;
    m_alu = 0; m_rd = 0; m_dest = 0; m_count = 0;
    e_fs1 = 0; e_fs2 = 0; e_fd = 0;
  endtask

  task automatic model_expect();
    bit mis;
    e_commit = m_valid && !stall;
    mis      = m_m2r && ref_misaligned(m_size, m_alo);
    e_we     = e_commit && m_rw && (m_dest != 0) && !mis;
    e_wd     = m_m2r ? ref_load(m_size, m_uns, m_alo, m_rd) : m_alu;
    e_align  = e_commit && mis;
  endtask

  task automatic model_check();
    model_expect();
    check_eq("reg_write", Reg_write, e_we);
    check_eq("align_err", align_err, e_align);
    check_eq("retired_count", retired_count, m_count);
    if (m_valid) begin
      check_eq("write_data", write_data, e_wd);
      check_eq("write_register", write_register, m_dest);
    end
`ifdef WRITEBACK_BYPASS_EN
    check_eq("fwd_sel1", fwd_sel1, e_fs1);
    check_eq("fwd_sel2", fwd_sel2, e_fs2);
    if (e_fs1 || e_fs2) check_eq("fwd_data", fwd_data, e_fd);
`endif
  endtask

  task automatic model_edge();
    model_expect();
`ifdef WRITEBACK_BYPASS_EN
    e_fs1 = e_we && (m_dest == rd_reg1);
    e_fs2 = e_we && (m_dest == rd_reg2);
    e_fd  = e_wd;
`endif
    if (e_commit) m_count = m_count + 1;
    if (flush) begin
      m_valid = 0;
    end else if (!stall) begin
      m_valid = bus.mem_valid;         m_rw   = bus.mem_reg_write;
      m_m2r   = bus.mem_mem_to_reg;    m_size = bus.mem_load_size;
      m_uns   = bus.mem_load_unsigned; m_alo  = bus.mem_addr_lo;
      m_alu   = bus.mem_alu_result;    m_rd   = bus.mem_read_data;
      m_dest  = bus.mem_write_register;
    end
  endtask

  task automatic run_cycle();
    #1 model_check();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic issue(input logic v, input logic rw, input logic m2r, input logic [1:0] sz,
                       input logic uns, input logic [1:0] alo, input logic [31:0] alu,
                       input logic [31:0] rd, input logic [4:0] dest);
    bus.mem_valid = v;           bus.mem_reg_write = rw;
    bus.mem_mem_to_reg = m2r;    bus.mem_load_size = sz;
    bus.mem_load_unsigned = uns; bus.mem_addr_lo = alo;
    bus.mem_alu_result = alu;    bus.mem_read_data = rd;
    bus.mem_write_register = dest;
  endtask

  task automatic idle();
    issue(0, 0, 0, 2'd0, 0, 2'd0, 32'h0, 32'h0, 5'd0);
  endtask

  logic [31:0] c0;

  initial begin
    rst = 1; stall = 0; flush = 0;
    idle();
`ifdef WRITEBACK_BYPASS_EN
    rd_reg1 = 0; rd_reg2 = 0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_reg_write", Reg_write, 1'b0);
    check_eq("rst_write_data", write_data, 32'h0);
    check_eq("rst_write_register", write_register, 5'd0);
    check_eq("rst_align_err", align_err, 1'b0);
    check_eq("rst_retired", retired_count, 32'd0);
`ifdef WRITEBACK_BYPASS_EN
    check_eq("rst_fwd_sel1", fwd_sel1, 1'b0);
    check_eq("rst_fwd_sel2", fwd_sel2, 1'b0);
    check_eq("rst_fwd_data", fwd_data, 32'h0);
`endif
    rst = 0;

    // ALU write to r5
    issue(1, 1, 0, 2'd2, 0, 2'd0, 32'h0000_1234, 32'h0, 5'd5);
    run_cycle();
    idle();
    #1;
    check_eq("alu_we", Reg_write, 1'b1);
    check_eq("alu_wr", write_register, 5'd5);
    check_eq("alu_wd", write_data, 32'h0000_1234);
    run_cycle();
    check_eq("alu_count", retired_count, 32'd1);

    // lb / lbu / lh on 0x80FF_7F01
    issue(1, 1, 1, 2'd0, 0, 2'd0, 32'h0, 32'h80FF_7F01, 5'd3);
    run_cycle();
    issue(1, 1, 1, 2'd0, 1, 2'd1, 32'h0, 32'h80FF_7F01, 5'd3);
    #1 check_eq("lb_wd", write_data, 32'hFFFF_FF80);
    run_cycle();
    issue(1, 1, 1, 2'd1, 0, 2'd2, 32'h0, 32'h80FF_7F01, 5'd3);
    #1 check_eq("lbu_wd", write_data, 32'h0000_00FF);
    run_cycle();
    issue(1, 1, 0, 2'd2, 0, 2'd0, 32'hDEAD_BEEF, 32'h0, 5'd0);
    #1 check_eq("lh_wd", write_data, 32'h0000_7F01);
    run_cycle();

    // write to r0: no bank write but still retired
    idle();
    c0 = m_count;
    #1 check_eq("r0_we", Reg_write, 1'b0);
    run_cycle();
    check_eq("r0_count", retired_count, c0 + 1);

    // misaligned lw
    issue(1, 1, 1, 2'd2, 0, 2'd2, 32'h0, 32'h1111_2222, 5'd6);
    run_cycle();
    idle();
    c0 = m_count;
    #1 check_eq("lw_mis_align", align_err, 1'b1);
    check_eq("lw_mis_we", Reg_write, 1'b0);
    run_cycle();
    check_eq("lw_mis_count", retired_count, c0 + 1);
    #1 check_eq("lw_mis_align_clear", align_err, 1'b0);
    run_cycle();

    // stall held three cycles, then exactly one write
    issue(1, 1, 0, 2'd2, 0, 2'd0, 32'h0000_0099, 32'h0, 5'd9);
    run_cycle();
    stall = 1;
    issue(1, 1, 0, 2'd2, 0, 2'd0, 32'h0000_0777, 32'h0, 5'd11);
    c0 = m_count;
    for (int i = 0; i < 3; i++) begin
      #1 check_eq("stall_we", Reg_write, 1'b0);
      run_cycle();
    end
    check_eq("stall_count_held", retired_count, c0);
    stall = 0;
    idle();
    #1 check_eq("release_we", Reg_write, 1'b1);
    check_eq("release_wd", write_data, 32'h0000_0099);
    check_eq("release_wr", write_register, 5'd9);
    run_cycle();
    check_eq("release_count", retired_count, c0 + 1);
    #1 check_eq("release_once", Reg_write, 1'b0);
    run_cycle();

    // flush + stall discards the held instruction
    issue(1, 1, 0, 2'd2, 0, 2'd0, 32'h0000_0055, 32'h0, 5'd10);
    run_cycle();
    stall = 1; flush = 1;
    idle();
    c0 = m_count;
    #1 check_eq("flush_stall_we", Reg_write, 1'b0);
    run_cycle();
    stall = 0; flush = 0;
    #1 check_eq("flush_after_we", Reg_write, 1'b0);
    run_cycle();
    check_eq("flush_count", retired_count, c0);

`ifdef WRITEBACK_BYPASS_EN
    // same-edge bypass of r7
    issue(1, 1, 0, 2'd2, 0, 2'd0, 32'hCAFE_0001, 32'h0, 5'd7);
    run_cycle();
    idle();
    rd_reg1 = 5'd7; rd_reg2 = 5'd0;
    run_cycle();
    #1 check_eq("byp_sel1", fwd_sel1, 1'b1);
    check_eq("byp_sel2", fwd_sel2, 1'b0);
    check_eq("byp_data", fwd_data, 32'hCAFE_0001);
    run_cycle();
`endif

    // reset asserted mid-stall clears immediately
    issue(1, 1, 0, 2'd2, 0, 2'd0, 32'h0000_0042, 32'h0, 5'd4);
    run_cycle();
    stall = 1;
    #1 check_eq("midrst_pre_we", Reg_write, 1'b0);
    rst = 1;
    #1 check_eq("midrst_count", retired_count, 32'd0);
    check_eq("midrst_we", Reg_write, 1'b0);
    check_eq("midrst_wr", write_register, 5'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 0; stall = 0;
    idle();
    run_cycle();

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      stall = ($urandom % 4) == 0;
      flush = ($urandom % 8) == 0;
      issue(($urandom % 4) != 0, ($urandom % 4) != 0, $urandom % 2, 2'($urandom % 4),
            $urandom % 2, 2'($urandom % 4), $urandom, $urandom, 5'($urandom % 8));
`ifdef WRITEBACK_BYPASS_EN
      rd_reg1 = 5'($urandom % 8);
      rd_reg2 = 5'($urandom % 8);
`endif
      run_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
